pipe_hazard_ctrl: RTL and testbench



---
 rtl/pipe_hazard_ctrl_pkg.sv | 31 +++
 rtl/pipe_fwd_sel.sv | 47 ++++
 rtl/pipe_hazard_ctrl.sv | 224 ++++++++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard controller.
// Slot record, D-side FSM states and forward-select helpers.
package pipe_hazard_ctrl_pkg;

  localparam int REG_W = 5;
  localparam int FWD_REGFILE = 0;

  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] rs1;
    logic [REG_W-1:0] rs2;
    logic [REG_W-1:0] rd;
    logic             rs1_rd;
    logic             rs2_rd;
    logic             wb;
    logic             load;
    logic             store;
    logic             branch;
  } slot_t;

  typedef enum logic [1:0] {
    D_IDLE,
    D_WAIT,
    D_DONE
  } d_state_t;

  function automatic int fw_width(input int n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/pipe_fwd_sel.sv
// Youngest-match forwarding scan for one source operand.
// Reports load-use when the nearest producer is a too-young load.
module pipe_fwd_sel
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int NUM_SLOTS = 4,
  parameter int LOAD_FWD_SLOT = 2,
  localparam int FW = fw_width(NUM_SLOTS)
) (
  input  logic                             en,
  input  logic [REG_W-1:0]                 rs,
  input  logic [NUM_SLOTS-1:1]             cand,
  input  logic [NUM_SLOTS-1:1]             is_ld,
  input  logic [NUM_SLOTS-1:1][REG_W-1:0]  rd_v,
  output logic [FW-1:0]                    sel,
  output logic                             load_use
);

  logic          hit;
  logic          hit_ld;
  logic [FW-1:0] hit_k;

  // Scan oldest to youngest so the youngest producer wins.
  always_comb begin
    hit    = 1'b0;
    hit_ld = 1'b0;
    hit_k  = '0;
    for (int k = NUM_SLOTS - 1; k >= 1; k--) begin
      if (cand[k] && rd_v[k] == rs) begin
        hit    = 1'b1;
        hit_k  = FW'(k);
        hit_ld = is_ld[k] && (k < LOAD_FWD_SLOT);
      end
    end
  end

  // x0 and unread operands always take the register file.
  always_comb begin
    sel      = FW'(FWD_REGFILE);
    load_use = 1'b0;
    if (en && rs != '0 && hit) begin
      if (hit_ld) load_use = 1'b1;
      else        sel      = hit_k;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// RV32I hazard/sequencing controller: forward, stall, flush, D-side.
// Optional perf counters under PIPE_HAZARD_PERF_EN.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int NUM_SLOTS = 4,
  parameter int BR_SLOT = 1,
  parameter int MEM_SLOT = 2,
  parameter int LOAD_FWD_SLOT = 2,
  localparam int FW = fw_width(NUM_SLOTS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 dec_valid,
  input  logic [REG_W-1:0]     dec_rs1,
  input  logic [REG_W-1:0]     dec_rs2,
  input  logic [REG_W-1:0]     dec_rd,
  input  logic                 dec_rs1_rd,
  input  logic                 dec_rs2_rd,
  input  logic                 dec_wb,
  input  logic                 dec_load,
  input  logic                 dec_store,
  input  logic                 dec_branch,
  input  logic                 br_taken,
  input  logic                 i_resp,
  input  logic                 d_resp,
  output logic [NUM_SLOTS-1:0] stall,
  output logic [NUM_SLOTS-1:0] bubble,
  output logic [NUM_SLOTS-1:0] slot_valid,
  output logic [FW-1:0]        fwd1_sel,
  output logic [FW-1:0]        fwd2_sel,
  output logic                 d_read,
  output logic                 d_write,
  output logic                 wb_en,
  output logic [REG_W-1:0]     wb_rd
`ifdef PIPE_HAZARD_PERF_EN
  ,
  output logic [31:0]          perf_stall_cnt,
  output logic [31:0]          perf_loaduse_cnt,
  output logic [31:0]          perf_flush_cnt
`endif
);

  if (!(BR_SLOT >= 1 && BR_SLOT < MEM_SLOT &&
        MEM_SLOT <= LOAD_FWD_SLOT &&
        LOAD_FWD_SLOT <= NUM_SLOTS - 1 &&
        NUM_SLOTS >= 3)) begin : g_bad_params
    $error("pipe_hazard_ctrl: illegal slot parameters");
  end

  // A taken branch squashes everything younger than it,
  // including the instruction arriving from decode.
  localparam logic [NUM_SLOTS-1:0] FLUSH_MASK =
    NUM_SLOTS'((1 << (BR_SLOT + 1)) - 1);

  slot_t [NUM_SLOTS-1:0] slots;
  slot_t                 dec_slot;
  d_state_t              d_st;
  d_state_t              d_st_nxt;

  logic mem_op;
  logic d_busy;
  logic stall_all;
  logic flush;
  logic lu1;
  logic lu2;
  logic load_use;
  logic unused_tail;

  logic [NUM_SLOTS-1:1]            cand;
  logic [NUM_SLOTS-1:1]            is_ld;
  logic [NUM_SLOTS-1:1][REG_W-1:0] rd_v;

  // Pack decode inputs into a slot record.
  always_comb begin
    dec_slot        = '0;
    dec_slot.valid  = dec_valid;
    dec_slot.rs1    = dec_rs1;
    dec_slot.rs2    = dec_rs2;
    dec_slot.rd     = dec_rd;
    dec_slot.rs1_rd = dec_rs1_rd;
    dec_slot.rs2_rd = dec_rs2_rd;
    dec_slot.wb     = dec_wb;
    dec_slot.load   = dec_load;
    dec_slot.store  = dec_store;
    dec_slot.branch = dec_branch;
  end

  // Producer candidates seen by the forward scanners.
  always_comb begin
    for (int k = 1; k < NUM_SLOTS; k++) begin
      cand[k]  = slots[k].valid && slots[k].wb;
      is_ld[k] = slots[k].load;
      rd_v[k]  = slots[k].rd;
    end
  end

  pipe_fwd_sel #(
    .NUM_SLOTS    (NUM_SLOTS),
    .LOAD_FWD_SLOT(LOAD_FWD_SLOT)
  ) u_fwd1 (
    .en      (slots[0].valid && slots[0].rs1_rd),
    .rs      (slots[0].rs1),
    .cand    (cand),
    .is_ld   (is_ld),
    .rd_v    (rd_v),
    .sel     (fwd1_sel),
    .load_use(lu1)
  );

  pipe_fwd_sel #(
    .NUM_SLOTS    (NUM_SLOTS),
    .LOAD_FWD_SLOT(LOAD_FWD_SLOT)
  ) u_fwd2 (
    .en      (slots[0].valid && slots[0].rs2_rd),
    .rs      (slots[0].rs2),
    .cand    (cand),
    .is_ld   (is_ld),
    .rd_v    (rd_v),
    .sel     (fwd2_sel),
    .load_use(lu2)
  );

  // Global hold: I-side miss or D-side op still outstanding.
  always_comb begin
    mem_op = slots[MEM_SLOT].valid &&
             (slots[MEM_SLOT].load || slots[MEM_SLOT].store);
    d_busy = mem_op && d_st != D_DONE && !d_resp;
    stall_all = !i_resp || d_busy;
    flush = slots[BR_SLOT].valid && slots[BR_SLOT].branch &&
            br_taken;
    load_use = lu1 || lu2;
  end

  // Per-slot hold and bubble; flush beats load-use.
  always_comb begin
    stall  = '0;
    bubble = '0;
    if (stall_all) begin
      stall = '1;
    end else if (flush) begin
      bubble = FLUSH_MASK;
    end else if (load_use) begin
      stall[0]  = 1'b1;
      bubble[1] = 1'b1;
    end
  end

  // Memory request, writeback and slot status outputs.
  always_comb begin
    d_read  = slots[MEM_SLOT].valid && slots[MEM_SLOT].load &&
              d_st != D_DONE;
    d_write = slots[MEM_SLOT].valid && slots[MEM_SLOT].store &&
              d_st != D_DONE;
    wb_en   = slots[NUM_SLOTS-1].valid && slots[NUM_SLOTS-1].wb;
    wb_rd   = wb_en ? slots[NUM_SLOTS-1].rd : '0;
    for (int k = 0; k < NUM_SLOTS; k++) begin
      slot_valid[k] = slots[k].valid;
    end
  end

  assign unused_tail = ^slots[NUM_SLOTS-1];

  // Slot shift register with hold, bubble and squash.
  always_ff @(posedge clk) begin
    if (rst) begin
      slots <= '0;
    end else if (!stall_all) begin
      for (int k = NUM_SLOTS - 1; k >= 1; k--) begin
        slots[k] <= bubble[k] ? '0 : slots[k-1];
      end
      if (bubble[0])     slots[0] <= '0;
      else if (stall[0]) slots[0] <= slots[0];
      else               slots[0] <= dec_slot;
    end
  end

  // D-side state register.
  always_ff @(posedge clk) begin
    if (rst) d_st <= D_IDLE;
    else     d_st <= d_st_nxt;
  end

  // D-side next state; DONE blocks re-issue until advance.
  always_comb begin
    d_st_nxt = d_st;
    unique case (d_st)
      D_IDLE: begin
        if (mem_op) begin
          if (!d_resp)     d_st_nxt = D_WAIT;
          else if (i_resp) d_st_nxt = D_IDLE;
          else             d_st_nxt = D_DONE;
        end
      end
      D_WAIT: begin
        if (d_resp) d_st_nxt = i_resp ? D_IDLE : D_DONE;
      end
      D_DONE: begin
        if (!stall_all) d_st_nxt = D_IDLE;
      end
      default: d_st_nxt = D_IDLE;
    endcase
  end

`ifdef PIPE_HAZARD_PERF_EN
  // Saturating event counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_cnt   <= '0;
      perf_loaduse_cnt <= '0;
      perf_flush_cnt   <= '0;
    end else begin
      if (stall_all && perf_stall_cnt != '1)
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
      if (!stall_all && !flush && load_use &&
          perf_loaduse_cnt != '1)
        perf_loaduse_cnt <= perf_loaduse_cnt + 32'd1;
      if (!stall_all && flush && perf_flush_cnt != '1)
        perf_flush_cnt <= perf_flush_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Random scoreboard bench for pipe_hazard_ctrl.
// Reference model tracks instructions and a D-data-received flag.
module tb_pipe_hazard_ctrl;

  localparam int N   = 4;
  localparam int BR  = 1;
  localparam int MS  = 2;
  localparam int LFS = 2;
  localparam int FW  = 3;
  localparam int NCYC = 3000;

  logic clk = 1'b0;
  logic rst;
  logic dec_valid;
  logic [4:0] dec_rs1, dec_rs2, dec_rd;
  logic dec_rs1_rd, dec_rs2_rd;
  logic dec_wb, dec_load, dec_store, dec_branch;
  logic br_taken, i_resp, d_resp;
  logic [N-1:0] stall, bubble, slot_valid;
  logic [FW-1:0] fwd1_sel, fwd2_sel;
  logic d_read, d_write, wb_en;
  logic [4:0] wb_rd;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(
    .NUM_SLOTS(N), .BR_SLOT(BR),
    .MEM_SLOT(MS), .LOAD_FWD_SLOT(LFS)
  ) dut (
    .clk(clk), .rst(rst),
    .dec_valid(dec_valid),
    .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
    .dec_rd(dec_rd),
    .dec_rs1_rd(dec_rs1_rd), .dec_rs2_rd(dec_rs2_rd),
    .dec_wb(dec_wb), .dec_load(dec_load),
    .dec_store(dec_store), .dec_branch(dec_branch),
    .br_taken(br_taken), .i_resp(i_resp),
    .d_resp(d_resp),
    .stall(stall), .bubble(bubble),
    .slot_valid(slot_valid),
    .fwd1_sel(fwd1_sel), .fwd2_sel(fwd2_sel),
    .d_read(d_read), .d_write(d_write),
    .wb_en(wb_en), .wb_rd(wb_rd)
  );

  typedef struct {
    bit v;
    int rs1, rs2, rd;
    bit r1, r2, wb, ld, st, br;
  } ins_t;

  typedef struct {
    logic [N-1:0]  stall, bubble, sv;
    logic [FW-1:0] f1, f2;
    logic          dr, dw, we;
    logic [4:0]    wrd;
  } exp_t;

  ins_t pipe[N];
  bit   d_got;
  exp_t q[$];
  int   checks = 0;
  int   passed = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h want %0h @%0t",
                  nm, act, exp, $time);
  endtask

  // Nearest older writer of rs decides forward vs load-use.
  function automatic void fwd(input int rs, input bit en,
                              output int sel, output bit lu);
    sel = 0;
    lu  = 0;
    if (!pipe[0].v || !en || rs == 0) return;
    for (int k = 1; k < N; k++) begin
      if (pipe[k].v && pipe[k].wb && pipe[k].rd == rs) begin
        if (pipe[k].ld && k < LFS) lu = 1;
        else sel = k;
        return;
      end
    end
  endfunction

  function automatic void model_eval(output exp_t e,
                                     output bit sa,
                                     output bit fl,
                                     output bit lu);
    bit memop, l1, l2;
    int s1, s2;
    memop = pipe[MS].v && (pipe[MS].ld || pipe[MS].st);
    sa = !i_resp || (memop && !d_got && !d_resp);
    fwd(pipe[0].rs1, pipe[0].r1, s1, l1);
    fwd(pipe[0].rs2, pipe[0].r2, s2, l2);
    lu = l1 || l2;
    fl = pipe[BR].v && pipe[BR].br && br_taken;
    e.stall  = '0;
    e.bubble = '0;
    if (sa) e.stall = '1;
    else if (fl) begin
      for (int k = 0; k <= BR; k++) e.bubble[k] = 1'b1;
    end else if (lu) begin
      e.stall[0]  = 1'b1;
      e.bubble[1] = 1'b1;
    end
    e.f1 = FW'(s1);
    e.f2 = FW'(s2);
    e.dr = pipe[MS].v && pipe[MS].ld && !d_got;
    e.dw = pipe[MS].v && pipe[MS].st && !d_got;
    e.we = pipe[N-1].v && pipe[N-1].wb;
    e.wrd = e.we ? 5'(pipe[N-1].rd) : 5'd0;
    for (int k = 0; k < N; k++) e.sv[k] = pipe[k].v;
  endfunction

  // Clock edge: move instructions or record D data arrival.
  function automatic void model_step();
    exp_t e;
    bit sa, fl, lu, memop;
    ins_t np[N];
    ins_t nop;
    ins_t din;
    nop = '{default: 0};
    if (rst) begin
      foreach (pipe[k]) pipe[k] = nop;
      d_got = 0;
      return;
    end
    model_eval(e, sa, fl, lu);
    memop = pipe[MS].v && (pipe[MS].ld || pipe[MS].st);
    if (sa) begin
      d_got = d_got || (memop && d_resp);
      return;
    end
    d_got = 0;
    din = '{v: dec_valid, rs1: int'(dec_rs1),
            rs2: int'(dec_rs2), rd: int'(dec_rd),
            r1: dec_rs1_rd, r2: dec_rs2_rd,
            wb: dec_wb, ld: dec_load,
            st: dec_store, br: dec_branch};
    for (int k = 1; k < N; k++) np[k] = pipe[k-1];
    np[0] = din;
    if (fl) begin
      for (int k = 0; k <= BR; k++) np[k] = nop;
    end else if (lu) begin
      np[0] = pipe[0];
      np[1] = nop;
    end
    pipe = np;
  endfunction

  task automatic rand_inputs(input int cyc);
    int cls;
    rst = (cyc < 2) || ($urandom_range(0, 99) == 0);
    dec_valid = ($urandom_range(0, 9) != 0);
    dec_rs1 = 5'($urandom_range(0, 3));
    dec_rs2 = 5'($urandom_range(0, 3));
    dec_rd  = 5'($urandom_range(0, 3));
    dec_rs1_rd = ($urandom_range(0, 4) != 0);
    dec_rs2_rd = ($urandom_range(0, 2) != 0);
    cls = int'($urandom_range(0, 3));
    dec_wb     = (cls <= 1);
    dec_load   = (cls == 1);
    dec_store  = (cls == 2);
    dec_branch = (cls == 3);
    br_taken = ($urandom_range(0, 2) == 0);
    i_resp   = ($urandom_range(0, 6) != 0);
    d_resp   = ($urandom_range(0, 4) < 2);
  endtask

  // Monitor: compare every presented output against the queue.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("stall",  32'(stall),      32'(e.stall));
        chk("bubble", 32'(bubble),     32'(e.bubble));
        chk("valid",  32'(slot_valid), 32'(e.sv));
        chk("fwd1",   32'(fwd1_sel),   32'(e.f1));
        chk("fwd2",   32'(fwd2_sel),   32'(e.f2));
        chk("d_read", 32'(d_read),     32'(e.dr));
        chk("d_write",32'(d_write),    32'(e.dw));
        chk("wb_en",  32'(wb_en),      32'(e.we));
        chk("wb_rd",  32'(wb_rd),      32'(e.wrd));
      end
    end
  end

  // Driver: step model, apply new inputs, push expectation.
  initial begin
    exp_t e;
    bit sa, fl, lu;
    rst = 1'b1;
    dec_valid = 0; dec_rs1 = 0; dec_rs2 = 0; dec_rd = 0;
    dec_rs1_rd = 0; dec_rs2_rd = 0; dec_wb = 0;
    dec_load = 0; dec_store = 0; dec_branch = 0;
    br_taken = 0; i_resp = 1; d_resp = 0;
    foreach (pipe[k]) pipe[k] = '{default: 0};
    d_got = 0;
    for (int c = 0; c < NCYC; c++) begin
      @(posedge clk);
      #1;
      model_step();
      rand_inputs(c);
      model_eval(e, sa, fl, lu);
      q.push_back(e);
    end
    @(negedge clk);
    #1;
    chk("drain", 32'(q.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
